// File: rtl/int_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, flush-aware, single tagged result to the CDB.
package riscv_pkg;
  localparam int ReorderBufferTagWidth = 5;
endpackage

module int_div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = ReorderBufferTagWidth
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_issue_valid,
  input  logic [TAG_W-1:0] i_issue_rob_tag,
  input  logic [31:0]      i_issue_op,
  input  logic [63:0]      i_issue_src1_value,
  input  logic [63:0]      i_issue_src2_value,
  output logic             o_fu_ready,
  output logic             o_result_valid,
  output logic [TAG_W-1:0] o_result_tag,
  output logic [63:0]      o_result_value,
  input  logic             i_result_grant,
  input  logic             i_flush_en,
  input  logic [TAG_W-1:0] i_flush_tag,
  input  logic [TAG_W-1:0] i_rob_head_tag,
  input  logic             i_flush_all
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [1:0]        op_q, op_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [63:0]       res_q, res_d;

  logic [XLEN-1:0]   a, b, mag_a, mag_b;
  logic              signed_op, a_neg, b_neg;
  logic [XLEN:0]     r_sh, r_nx;
  logic [XLEN-1:0]   q_nx, q_fix, r_fix;
  logic              ge, kill, drop, accept;
  logic              unused_ok;

  // Age of t relative to the ROB head exceeds that of the flush tag
  function automatic logic younger(
    input logic [TAG_W-1:0] t,
    input logic [TAG_W-1:0] f,
    input logic [TAG_W-1:0] h
  );
    logic [TAG_W-1:0] dt, df;
    dt = t - h;
    df = f - h;
    return dt > df;
  endfunction

  assign unused_ok = ^{i_issue_op[31:2],
                       i_issue_src1_value[63:32],
                       i_issue_src2_value[63:32],
                       r_nx[XLEN]};

  assign o_fu_ready     = (state_q == S_IDLE);
  assign o_result_valid = (state_q == S_DONE);
  assign o_result_tag   = tag_q;
  assign o_result_value = res_q;

  // Operand prep, restoring step, flush decisions and next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    op_d    = op_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;

    a         = i_issue_src1_value[XLEN-1:0];
    b         = i_issue_src2_value[XLEN-1:0];
    signed_op = ~i_issue_op[0];
    a_neg     = signed_op & a[XLEN-1];
    b_neg     = signed_op & b[XLEN-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;

    r_sh  = {rem_q, quo_q[XLEN-1]};
    ge    = (r_sh >= {1'b0, div_q});
    r_nx  = ge ? (r_sh - {1'b0, div_q}) : r_sh;
    q_nx  = {quo_q[XLEN-2:0], ge};
    q_fix = qsign_q ? -q_nx : q_nx;
    r_fix = rsign_q ? -r_nx[XLEN-1:0] : r_nx[XLEN-1:0];

    kill = i_flush_all |
           (i_flush_en & younger(tag_q, i_flush_tag, i_rob_head_tag));
    drop = i_flush_all |
           (i_flush_en &
            younger(i_issue_rob_tag, i_flush_tag, i_rob_head_tag));
    accept = i_issue_valid & (state_q == S_IDLE) & ~drop;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_d   = i_issue_rob_tag;
          op_d    = i_issue_op[1:0];
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          div_d   = mag_b;
          quo_d   = mag_a;
          rem_d   = '0;
          cnt_d   = 5'd31;
          if (b == '0) begin
            state_d = S_DONE;
            res_d   = {{(64-XLEN){1'b0}},
                       i_issue_op[1] ? a : {XLEN{1'b1}}};
          end else if (signed_op && a == MinNeg && b == '1) begin
            state_d = S_DONE;
            res_d   = {{(64-XLEN){1'b0}},
                       i_issue_op[1] ? {XLEN{1'b0}} : MinNeg};
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          rem_d = r_nx[XLEN-1:0];
          quo_d = q_nx;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            cnt_d   = 5'd0;
            state_d = S_DONE;
            res_d   = {{(64-XLEN){1'b0}}, op_q[1] ? r_fix : q_fix};
          end
        end
      end
      S_DONE: begin
        if (kill || i_result_grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      op_q    <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_int_div_unit.sv
// Directed bench for int_div_unit: results, latency,
// back-pressure, flush and reset behaviour.
module tb_int_div_unit;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_tag = '0;
  logic [31:0] issue_op = '0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        fu_ready;
  logic        res_valid;
  logic [4:0]  res_tag;
  logic [63:0] res_value;
  logic        grant = 1'b0;
  logic        flush_en = 1'b0;
  logic [4:0]  flush_tag = '0;
  logic [4:0]  head = '0;
  logic        flush_all = 1'b0;

  int checks = 0;
  int failures = 0;
  int n;
  logic seen;

  int_div_unit dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_issue_valid      (issue_valid),
    .i_issue_rob_tag    (issue_tag),
    .i_issue_op         (issue_op),
    .i_issue_src1_value (src1),
    .i_issue_src2_value (src2),
    .o_fu_ready         (fu_ready),
    .o_result_valid     (res_valid),
    .o_result_tag       (res_tag),
    .o_result_value     (res_value),
    .i_result_grant     (grant),
    .i_flush_en         (flush_en),
    .i_flush_tag        (flush_tag),
    .i_rob_head_tag     (head),
    .i_flush_all        (flush_all)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    issue_valid = 1'b1;
    issue_op    = {30'h2AAA_AAAA, op};
    src1        = {32'hDEAD_BEEF, a};
    src2        = {32'hCAFE_F00D, b};
    issue_tag   = tag;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!res_valid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_quiet(input int cycles, output logic hit);
    hit = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (res_valid) hit = 1'b1;
    end
  endtask

  task automatic do_grant(input string nm);
    grant = 1'b1;
    @(posedge clk);
    #1;
    grant = 1'b0;
    check({nm, "_rdy"}, {63'd0, fu_ready}, 64'd1);
  endtask

  task automatic run(input string nm, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input logic [63:0] exp,
                     input int lat);
    int c;
    issue(op, a, b, tag);
    wait_valid(c);
    check({nm, "_lat"}, 64'(c), 64'(lat));
    check({nm, "_tag"}, {59'd0, res_tag}, {59'd0, tag});
    check({nm, "_val"}, res_value, exp);
    do_grant(nm);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", {63'd0, fu_ready}, 64'd1);
    check("rst_vld", {63'd0, res_valid}, 64'd0);
    check("rst_tag", {59'd0, res_tag}, 64'd0);
    check("rst_val", res_value, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("divu", OP_DIVU, 32'd100, 32'd7, 5'd3, 64'd14, 33);
    run("remu", OP_REMU, 32'd100, 32'd7, 5'd3, 64'd2, 33);
    run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4,
        64'h0000_0000_FFFF_FFFD, 33);
    run("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4,
        64'h0000_0000_FFFF_FFFF, 33);
    run("div_neg_dvsr", OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd5,
        64'h0000_0000_FFFF_FFF2, 33);
    run("div_z", OP_DIV, 32'd5, 32'd0, 5'd8,
        64'h0000_0000_FFFF_FFFF, 1);
    run("remu_z", OP_REMU, 32'd5, 32'd0, 5'd8, 64'd5, 1);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
        64'h0000_0000_8000_0000, 1);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
        64'd0, 1);
    run("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10,
        64'd0, 33);

    issue(OP_DIVU, 32'd100, 32'd7, 5'd6);
    wait_valid(n);
    check("bp_lat", 64'(n), 64'd33);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("bp_vld", {63'd0, res_valid}, 64'd1);
    check("bp_rdy", {63'd0, fu_ready}, 64'd0);
    check("bp_tag", {59'd0, res_tag}, 64'd6);
    check("bp_val", res_value, 64'd14);
    do_grant("bp");
    run("bp_next", OP_REMU, 32'd100, 32'd7, 5'd7, 64'd2, 33);

    head = 5'd30;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd2);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    flush_en  = 1'b1;
    flush_tag = 5'd1;
    @(posedge clk);
    #1;
    flush_en = 1'b0;
    check("fl_kill_rdy", {63'd0, fu_ready}, 64'd1);
    wait_quiet(40, seen);
    check("fl_kill_quiet", {63'd0, seen}, 64'd0);

    issue(OP_DIVU, 32'd100, 32'd7, 5'd2);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    flush_en  = 1'b1;
    flush_tag = 5'd4;
    @(posedge clk);
    #1;
    flush_en = 1'b0;
    check("fl_keep_rdy", {63'd0, fu_ready}, 64'd0);
    wait_valid(n);
    check("fl_keep_vld", {63'd0, res_valid}, 64'd1);
    check("fl_keep_tag", {59'd0, res_tag}, 64'd2);
    check("fl_keep_val", res_value, 64'd14);
    do_grant("fl_keep");

    issue(OP_DIV, 32'd5, 32'd0, 5'd2);
    wait_valid(n);
    check("fa_done_vld", {63'd0, res_valid}, 64'd1);
    flush_all = 1'b1;
    @(posedge clk);
    #1;
    flush_all = 1'b0;
    check("fa_done_fall", {63'd0, res_valid}, 64'd0);
    check("fa_done_rdy", {63'd0, fu_ready}, 64'd1);

    flush_all = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
    flush_all = 1'b0;
    check("fa_iss_rdy", {63'd0, fu_ready}, 64'd1);
    wait_quiet(40, seen);
    check("fa_iss_quiet", {63'd0, seen}, 64'd0);

    flush_en  = 1'b1;
    flush_tag = 5'd1;
    issue(OP_DIV, 32'd5, 32'd0, 5'd2);
    flush_en = 1'b0;
    check("fe_iss_rdy", {63'd0, fu_ready}, 64'd1);
    wait_quiet(40, seen);
    check("fe_iss_quiet", {63'd0, seen}, 64'd0);

    issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", {63'd0, fu_ready}, 64'd1);
    check("mid_rst_vld", {63'd0, res_valid}, 64'd0);
    check("mid_rst_tag", {59'd0, res_tag}, 64'd0);
    check("mid_rst_val", res_value, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_quiet(40, seen);
    check("mid_rst_quiet", {63'd0, seen}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
